hc161_sync_counter: RTL

//   Synchronous presettable modulo-N up-counter modelled on the 74HC161, with
//   ENP/ENT count enables and a ripple-carry output (RCO).

---
 rtl/hc_pkg.sv | 14 +
 rtl/hc_tc_detect.sv | 17 +
 rtl/hc161_sync_counter.sv | 71 +++++++
 3 files changed

// File: rtl/hc_pkg.sv
// Shared constants and control-priority encoding for the hc161-style counter.
package hc_pkg;

  localparam int HC_CNT_WIDTH_DEF = 4;
  localparam int HC_CNT_MOD_DEF   = 16;

  typedef enum logic [1:0] {
    CTL_RESET,
    CTL_LOAD,
    CTL_COUNT,
    CTL_HOLD
  } hc_ctl_e;

endpackage

// File: rtl/hc_tc_detect.sv
// Terminal-count detector: tc marks Q==MODULUS-1; wrap also covers
// out-of-range loaded values so the next count returns to zero.
module hc_tc_detect #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

  assign tc   = (q == TERM);
  assign wrap = (q >= TERM);

endmodule

// File: rtl/hc161_sync_counter.sv
// Presettable modulo-N up-counter with ENP/ENT enables and ripple carry,
// whose carry also drives the J/K inputs of a downstream toggle stage.
module hc161_sync_counter
  import hc_pkg::*;
#(
  parameter int WIDTH   = HC_CNT_WIDTH_DEF,
  parameter int MODULUS = HC_CNT_MOD_DEF
) (
  input  logic             Clk,
  input  logic             R,
  input  logic             LD,
  input  logic             ENP,
  input  logic             ENT,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             J_out,
  output logic             K_out
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             tc;
  logic             wrap;
  hc_ctl_e          ctl;

  hc_tc_detect #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_tc_detect (
    .q   (q_reg),
    .tc  (tc),
    .wrap(wrap)
  );

  always_comb begin
    ctl = CTL_HOLD;
    if (R)
      ctl = CTL_RESET;
    else if (LD)
      ctl = CTL_LOAD;
    else if (ENP && ENT)
      ctl = CTL_COUNT;
  end

  // Wrap is decided before the increment, so Q never passes 2**WIDTH-1.
  always_comb begin
    q_next = q_reg;
    case (ctl)
      CTL_RESET: q_next = '0;
      CTL_LOAD:  q_next = D;
      CTL_COUNT: q_next = wrap ? '0 : (q_reg + ONE);
      default:   q_next = q_reg;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (R)
      q_reg <= '0;
    else
      q_reg <= q_next;
  end

  assign Q     = q_reg;
  assign RCO   = ENT & tc;
  assign J_out = RCO;
  assign K_out = RCO;

endmodule
